// File: rtl/rvv_pkg.sv
// Shared definitions for the vector destination writeback block:
// FSM state encoding, SEW codes and the SEW width helper.
package rvv_pkg;

    localparam logic [16:0] VLEN_DEFAULT = 17'd128;

    localparam logic [2:0] SEW_8  = 3'd0;
    localparam logic [2:0] SEW_16 = 3'd1;
    localparam logic [2:0] SEW_32 = 3'd2;
    localparam logic [2:0] SEW_64 = 3'd3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCUM  = 2'd1,
        ST_COMMIT = 2'd2
    } wb_state_t;

    // Element width in bits; 0 marks an illegal code so callers can drop writes.
    function automatic logic [6:0] sew_bits(input logic [2:0] vsew);
        case (vsew)
            SEW_8:   return 7'd8;
            SEW_16:  return 7'd16;
            SEW_32:  return 7'd32;
            SEW_64:  return 7'd64;
            default: return 7'd0;
        endcase
    endfunction

endpackage

// File: rtl/rvv_elem_insert.sv
// Combinational insertion of one lane result into the destination buffer.
// Handles SEW packing, mask-destination bits and lane-0 reduction results.
module rvv_elem_insert
    import rvv_pkg::*;
#(
    parameter logic [16:0] VLEN  = VLEN_DEFAULT,
    parameter bit          LANE0 = 1'b0
) (
    input  logic [VLEN-1:0] i_buffer,
    input  logic            i_valid,
    input  logic [16:0]     i_idx,
    input  logic [63:0]     i_data,
    input  logic [2:0]      i_vsew,
    input  logic [16:0]     i_vl,
    input  logic            i_mask_dest,
    input  logic            i_reduction,
    output logic [VLEN-1:0] o_buffer,
    output logic            o_hit
);

    logic [6:0]  w_sew;
    logic        w_legal;
    logic [16:0] w_idx;
    logic [23:0] w_off;
    logic        w_wr_elem;
    logic        w_wr_mask;

    assign w_sew   = sew_bits(i_vsew);
    assign w_legal = (w_sew != 7'd0);
    assign w_idx   = i_reduction ? 17'd0 : i_idx;

    // Bit offset kept at 24 bits so a large index cannot wrap into range.
    assign w_off = {7'd0, w_idx} * {17'd0, w_sew};

    assign w_wr_elem = i_valid && w_legal &&
                       (i_reduction ? LANE0
                                    : (!i_mask_dest && (i_idx < i_vl) && (w_off < 24'(VLEN))));

    assign w_wr_mask = i_valid && w_legal && !i_reduction && i_mask_dest &&
                       (i_idx < i_vl) && (i_idx < VLEN);

    assign o_hit = w_wr_elem | w_wr_mask;

    for (genvar b = 0; b < VLEN; b++) begin : g_bit
        logic [23:0] w_rel;
        logic        w_elem_sel;
        logic        w_mask_sel;

        // Unsigned wrap makes bits below the offset compare as out of range.
        assign w_rel      = 24'(b) - w_off;
        assign w_elem_sel = w_wr_elem && (w_rel < {17'd0, w_sew});
        assign w_mask_sel = w_wr_mask && (i_idx == 17'(b));
        assign o_buffer[b] = w_elem_sel ? i_data[w_rel[5:0]] :
                             w_mask_sel ? i_data[0]          :
                                          i_buffer[b];
    end

endmodule

// File: rtl/rvv_vd_writeback.sv
// Collects per-lane ALU results into a VLEN-bit destination buffer seeded with
// the old register value, then commits it to the register file.
module rvv_vd_writeback
    import rvv_pkg::*;
#(
    parameter logic [16:0] VLEN     = VLEN_DEFAULT,
    parameter int          NB_LANES = 1,
    localparam int         L        = 1 << NB_LANES
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic [VLEN-1:0]  old_vd,
    input  logic [4:0]       vd_addr,
    input  logic [2:0]       vsew,
    input  logic [16:0]      vl,
    input  logic             mask_dest,
    input  logic             reduction,
    input  logic [L-1:0]     lane_valid,
    input  logic [64*L-1:0]  lane_vd,
    input  logic [17*L-1:0]  lane_idx,
    input  logic             alu_done,
    output logic             wr_valid,
    output logic [4:0]       wr_addr,
    output logic [VLEN-1:0]  wr_data,
    input  logic             wr_ready,
    output logic             busy
);

    wb_state_t       r_state;
    wb_state_t       w_state_next;
    logic [VLEN-1:0] r_buf;
    logic [4:0]      r_addr;
    logic [2:0]      r_vsew;
    logic [16:0]     r_vl;
    logic            r_mask_dest;
    logic            r_reduction;

    logic [VLEN-1:0] w_chain [0:L];
    logic [L-1:0]    w_hit;

    assign w_chain[0] = r_buf;

    // Lanes are chained in ascending order, so the highest lane wins a collision.
    for (genvar l = 0; l < L; l++) begin : g_lane
        rvv_elem_insert #(
            .VLEN  (VLEN),
            .LANE0 (l == 0)
        ) u_insert (
            .i_buffer    (w_chain[l]),
            .i_valid     (lane_valid[l]),
            .i_idx       (lane_idx[17*l +: 17]),
            .i_data      (lane_vd[64*l +: 64]),
            .i_vsew      (r_vsew),
            .i_vl        (r_vl),
            .i_mask_dest (r_mask_dest),
            .i_reduction (r_reduction),
            .o_buffer    (w_chain[l+1]),
            .o_hit       (w_hit[l])
        );
    end

    // Write port: wr_valid stays high with wr_addr/wr_data stable until the
    // cycle wr_valid && wr_ready, which is the single transfer of the commit.
    always_comb begin
        w_state_next = r_state;
        wr_valid     = 1'b0;
        busy         = 1'b1;
        case (r_state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    w_state_next = ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (alu_done) begin
                    w_state_next = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                wr_valid = 1'b1;
                if (wr_ready) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    assign wr_addr = r_addr;
    assign wr_data = r_buf;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state     <= ST_IDLE;
            r_buf       <= '0;
            r_addr      <= 5'd0;
            r_vsew      <= 3'd0;
            r_vl        <= 17'd0;
            r_mask_dest <= 1'b0;
            r_reduction <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (r_state == ST_IDLE && start) begin
                r_buf       <= old_vd;
                r_addr      <= vd_addr;
                r_vsew      <= vsew;
                r_vl        <= vl;
                r_mask_dest <= mask_dest;
                r_reduction <= reduction;
            end else if (r_state == ST_ACCUM && (|w_hit)) begin
                r_buf <= w_chain[L];
            end
        end
    end

endmodule

// File: doc/rvv_vd_writeback.md
Name: rvv_vd_writeback

Overview:
Downstream stage of the vector ALU wrapper. It collects the per-lane results (vd, element index, lane-valid) the ALU emits each cycle into a VLEN-bit destination buffer. The buffer is pre-loaded with the old destination value so tail elements are left undisturbed. When the ALU signals done, the block commits the assembled register to the vector register file over a valid/ready write port. It handles SEW packing, mask-destination (1 bit per element) writes and scalar reduction results.

Parameters:
VLEN, 17'd128, vector register width in bits.
NB_LANES, 1, log2 of lane count; lane count L = 1<<NB_LANES.

Ports:
clk  in  1  clock
resetn  in  1  reset; synchronous, active-low
start  in  1  begin instruction; sampled only in IDLE
old_vd  in  VLEN  current contents of destination register, captured on start
vd_addr  in  5  destination register index, captured on start
vsew  in  3  element width code: 0=8, 1=16, 2=32, 3=64; 4..7 illegal
vl  in  17  active vector length, captured on start
mask_dest  in  1  destination is a mask (1 bit per element), captured on start
reduction  in  1  scalar reduction result, captured on start
lane_valid  in  L  per-lane result valid (ALU res)
lane_vd  in  64*L  per-lane result data (ALU vd)
lane_idx  in  17*L  per-lane element index (ALU regi)
alu_done  in  1  ALU done pulse
wr_valid  out  1  register-file write request
wr_addr  out  5  register-file write index
wr_data  out  VLEN  register-file write data
wr_ready  in  1  register file accepts the write
busy  out  1  state != IDLE

Behaviour:
- Reset (sync, resetn=0): state=IDLE, buffer=0, wr_valid=0, wr_addr=0, wr_data=0, busy=0. Reset in any state aborts the instruction; no write is issued.
- States: IDLE, ACCUM, COMMIT.
- IDLE: on start, latch buffer<=old_vd, vd_addr, vsew, vl, mask_dest and reduction, then go to ACCUM. Lane inputs and alu_done are ignored in IDLE.
- ACCUM: each cycle, for each lane l with lane_valid[l]=1, let i = lane_idx[l], SEW = 8<<vsew, d = lane_vd[l].
  - Normal: if i < vl and i < VLEN/SEW, set buffer[i*SEW +: SEW] = d[SEW-1:0]. Otherwise drop the write.
  - mask_dest: if i < vl and i < VLEN, set buffer[i] = d[0]. Otherwise drop the write.
  - reduction: only lane 0 is used, and i is forced to 0. Set buffer[SEW-1:0] = d[SEW-1:0] on every valid lane-0 cycle, so the last one wins.
  - Illegal vsew (4..7): all writes are dropped; the commit still occurs with buffer = old_vd.
  - Two lanes targeting the same element in one cycle: the highest lane index wins.
- Done: alu_done=1 in ACCUM merges that cycle's lane data, then the state goes to COMMIT. wr_valid rises the next cycle (1-cycle latency from done).
- COMMIT:
  - wr_valid=1, wr_addr=latched address, wr_data=buffer.
  - Outputs are held stable while wr_ready=0.
  - On wr_valid&wr_ready, go to IDLE and drop wr_valid the next cycle.
  - start, lane_valid and alu_done are ignored in COMMIT.
- No back-to-back overlap: a new start is accepted only in IDLE, at the earliest the cycle after the handshake.
- Width rules: index compare is full 17-bit. The bit offset i*SEW is computed in 24 bits, so no truncation occurs before the range check.

Decomposition:
- Shared package rvv_pkg holds:
  - state encoding (IDLE/ACCUM/COMMIT);
  - SEW code constants and the function sew_bits(vsew);
  - VLEN default.
- One sub-module is natural: rvv_elem_insert. It is combinational, one instance per lane. Given buffer_in, idx, data, vsew, vl, mask_dest and reduction, it produces buffer_out and a hit flag.
- Lane instances are chained lane 0 -> L-1, which yields highest-lane-wins.

Test Plan:
(VLEN=128, NB_LANES=1, so 2 lanes.)
1. Basic pack: start with old_vd=all 0xAA, vsew=2, vl=4. Cycle1: lanes (idx0=0x11111111, idx1=0x22222222). Cycle2: (idx2=0x33333333, idx3=0x44444444) with alu_done. -> Next cycle wr_valid=1, wr_data=0x44444444_33333333_22222222_11111111, wr_addr=latched.
2. Tail undisturbed: same setup but vl=2; idx2 and idx3 are presented. -> wr_data[127:64]=0xAAAA…AA, wr_data[63:0]=0x22222222_11111111.
3. Mask destination: old_vd=0, mask_dest=1, vl=16. Lane0 idx5 d=1, lane1 idx6 d=0, then idx20 d=1 (out of range). -> wr_data=0x20.
4. Backpressure: hold wr_ready=0 for 3 COMMIT cycles and assert start mid-wait. -> wr_valid and wr_data stable, start ignored; after wr_ready=1, state is IDLE and busy=0 the next cycle.
5. Collision and reduction: both lanes idx0 with vsew=0 and data 0x5A/0xC3 -> byte0=0xC3. Separately, reduction with lane0 d=0x1234 at idx7, vsew=1 -> wr_data[15:0]=0x1234, rest = old.
6. Reset mid-ACCUM: start, one lane write, then resetn=0 for 1 cycle. -> wr_valid never asserted, busy=0. The next instruction commits a correct result from its own old_vd.
